// File: rtl/stream_demux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stream_demux_pkg
// Description : Shared constants and types for the 1-to-4 stream demultiplexer.
//               N_CH     - number of output channels (fixed at 4)
//               ch_sel_t - channel index / round-robin slot type
// Revision    : 1.0 - initial release
// ============================================================================
package stream_demux_pkg;

  localparam int N_CH = 4;

  typedef logic [1:0] ch_sel_t;

endpackage : stream_demux_pkg
`default_nettype wire

// File: rtl/stream_demux_slot.sv
`default_nettype none
// ============================================================================
// Module      : stream_demux_slot
// Description : One-entry valid/ready output register for a demux channel.
//               A load always wins over a drain, so a drain and a refill in
//               the same cycle keep the entry full and replace the data.
//               The data is not cleared when drained.
// Ports       : clk       - clock
//               rst_n     - synchronous reset, active low
//               load      - write load_data into the entry this cycle
//               load_data - word to store
//               out_valid - entry holds a word
//               out_ready - consumer takes the word this cycle
//               out_data  - stored word
//               full      - entry occupancy (same as out_valid)
// Revision    : 1.0 - initial release
// ============================================================================
module stream_demux_slot #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         full
);

  logic         full_q, full_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (load) begin
      full_d = 1'b1;
      data_d = load_data;
    end else if (full_q && out_ready) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign out_valid = full_q;
  assign full      = full_q;
  assign out_data  = data_q;

endmodule : stream_demux_slot
`default_nettype wire

// File: rtl/stream_demux_1_4.sv
`default_nettype none
// ============================================================================
// Module      : stream_demux_1_4
// Description : Registered 1-to-4 stream demultiplexer. Each input word is
//               steered either by in_sel or by an internal round-robin slot
//               counter (TDM de-interleave) into a one-entry buffer per lane.
//               Head-of-line blocking is intentional: a full, undrained
//               target stalls the input even if other lanes are free.
// Ports       : clk, rst_n          - clock, synchronous active-low reset
//               rr_mode            - 1: slot counter selects lane, 0: in_sel
//               in_valid/in_ready  - input handshake
//               in_data, in_sel    - input word and explicit target lane
//               out_valid/out_ready- per-lane output handshake
//               out_data0..3       - per-lane output words
//               slot               - current round-robin slot
// Revision    : 1.0 - initial release
// ============================================================================
module stream_demux_1_4 #(
  parameter int W    = 4,
  parameter int N_CH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rr_mode,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic [1:0]   in_sel,
  output logic [3:0]   out_valid,
  input  logic [3:0]   out_ready,
  output logic [W-1:0] out_data0,
  output logic [W-1:0] out_data1,
  output logic [W-1:0] out_data2,
  output logic [W-1:0] out_data3,
  output logic [1:0]   slot
);

  import stream_demux_pkg::*;

  // The channel decode and port list are hard-wired for four lanes.
  if (N_CH != stream_demux_pkg::N_CH) begin : g_bad_n_ch
    $error("stream_demux_1_4: N_CH must be 4");
  end

  ch_sel_t         slot_q, slot_d;
  ch_sel_t         ch;
  logic            accept;
  logic [3:0]      full;
  logic [3:0]      load;
  logic [W-1:0]    lane_data [4];

  // Target decode, input handshake and slot advance. in_ready is gated by
  // rst_n so nothing is accepted while reset is asserted.
  always_comb begin
    ch       = rr_mode ? slot_q : ch_sel_t'(in_sel);
    in_ready = rst_n & (~full[ch] | out_ready[ch]);
    accept   = in_valid & in_ready;
    slot_d   = slot_q;
    if (accept && rr_mode) begin
      slot_d = slot_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  for (genvar c = 0; c < 4; c++) begin : g_lane
    assign load[c] = accept & (ch == ch_sel_t'(c));

    stream_demux_slot #(
      .W (W)
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[c]),
      .load_data (in_data),
      .out_valid (out_valid[c]),
      .out_ready (out_ready[c]),
      .out_data  (lane_data[c]),
      .full      (full[c])
    );
  end

  assign out_data0 = lane_data[0];
  assign out_data1 = lane_data[1];
  assign out_data2 = lane_data[2];
  assign out_data3 = lane_data[3];
  assign slot      = slot_q;

endmodule : stream_demux_1_4
`default_nettype wire

// File: tb/tb_stream_demux_1_4.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_demux_1_4
// Description : Self-checking bench for stream_demux_1_4. Accepted words are
//               pushed to a scoreboard queue tagged with their lane and popped
//               and compared when the lane drains.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_demux_1_4;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         rr_mode;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [1:0]   in_sel;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic [W-1:0] out_data0, out_data1, out_data2, out_data3;
  logic [1:0]   slot;

  always #5 clk = ~clk;

  stream_demux_1_4 #(.W(W), .N_CH(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rr_mode   (rr_mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3),
    .slot      (slot)
  );

  typedef struct {
    logic [1:0]   ch;
    logic [W-1:0] data;
  } sb_entry_t;

  sb_entry_t    sb_q [$];
  logic [W-1:0] m_last [4];
  logic [1:0]   m_slot;
  int           n_checks = 0;
  int           n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic int sb_find(input logic [1:0] c);
    for (int i = 0; i < sb_q.size(); i++) begin
      if (sb_q[i].ch == c) return i;
    end
    return -1;
  endfunction

  task automatic drive(input logic v, input logic [1:0] sel, input logic [W-1:0] d);
    in_valid = v;
    in_sel   = sel;
    in_data  = d;
  endtask

  // One clock: check DUT outputs against the model at the falling edge,
  // advance the model to what the next rising edge should produce.
  task automatic cycle();
    logic [W-1:0] dd [4];
    logic [3:0]   m_full;
    logic [1:0]   ch;
    logic         exp_rdy;
    int           idx;
    @(negedge clk);
    dd[0] = out_data0; dd[1] = out_data1; dd[2] = out_data2; dd[3] = out_data3;
    for (int c = 0; c < 4; c++) m_full[c] = (sb_find(2'(c)) >= 0);
    ch      = rr_mode ? m_slot : in_sel;
    exp_rdy = rst_n & (!m_full[ch] | out_ready[ch]);
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    check("out_valid", 32'(out_valid), 32'(m_full));
    check("slot", 32'(slot), 32'(m_slot));
    for (int c = 0; c < 4; c++) check($sformatf("out_data%0d", c), 32'(dd[c]), 32'(m_last[c]));
    if (!rst_n) begin
      sb_q.delete();
      for (int c = 0; c < 4; c++) m_last[c] = '0;
      m_slot = 2'd0;
    end else begin
      for (int c = 0; c < 4; c++) begin
        if (m_full[c] && out_ready[c]) begin
          idx = sb_find(2'(c));
          check($sformatf("drain%0d", c), 32'(dd[c]), 32'(sb_q[idx].data));
          sb_q.delete(idx);
        end
      end
      if (in_valid && exp_rdy) begin
        sb_q.push_back('{ch: ch, data: in_data});
        m_last[ch] = in_data;
        if (rr_mode) m_slot = m_slot + 2'd1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    rr_mode   = 1'b0;
    out_ready = 4'b1111;
    drive(1'b0, 2'd0, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++) m_last[c] = '0;
    m_slot = 2'd0;
    // reset state, with an offered word that must not be accepted
    drive(1'b1, 2'd1, 4'h6);
    cycle();
    rst_n = 1'b1;
    drive(1'b0, 2'd0, 4'h0);
    cycle();

    // 1. explicit routing
    drive(1'b1, 2'd0, 4'hA); cycle();
    drive(1'b1, 2'd1, 4'hB); cycle();
    drive(1'b1, 2'd2, 4'hC); cycle();
    drive(1'b1, 2'd3, 4'hD); cycle();
    drive(1'b0, 2'd0, 4'h0); cycle();

    // 2. backpressure on lane 2, then drain-and-refill in one cycle
    out_ready = 4'b1011;
    drive(1'b1, 2'd2, 4'h7); cycle();
    drive(1'b1, 2'd2, 4'h3); cycle();
    check("bp_hold", 32'(out_data2), 32'h7);
    cycle();
    out_ready = 4'b1111;
    cycle();
    drive(1'b0, 2'd0, 4'h0); cycle();
    check("bp_refill", 32'(out_data2), 32'h3);

    // 3. round-robin with a gap after the second word
    rr_mode = 1'b1;
    drive(1'b1, 2'd3, 4'h1); cycle();
    drive(1'b1, 2'd3, 4'h2); cycle();
    drive(1'b0, 2'd3, 4'hF); cycle();
    drive(1'b1, 2'd3, 4'h3); cycle();
    drive(1'b1, 2'd3, 4'h4); cycle();
    drive(1'b1, 2'd3, 4'h5); cycle();
    drive(1'b0, 2'd0, 4'h0); cycle();
    check("rr_ch0", 32'(out_data0), 32'h5);
    check("rr_slot", 32'(slot), 32'h1);

    // 4. X pass-through to lane 3
    rr_mode = 1'b0;
    drive(1'b1, 2'd3, 4'bxxxx); cycle();
    drive(1'b0, 2'd0, 4'h0); cycle();
    check("x_pass", 32'(out_data3), 32'(4'bxxxx));

    // 5. reset mid-stream
    out_ready = 4'b0000;
    drive(1'b1, 2'd0, 4'h5); cycle();
    drive(1'b1, 2'd1, 4'h6); cycle();
    rst_n = 1'b0;
    drive(1'b1, 2'd2, 4'h9); cycle();
    rst_n = 1'b1;
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_data0", 32'(out_data0), 32'h0);
    drive(1'b1, 2'd2, 4'h9); cycle();
    out_ready = 4'b1111;
    drive(1'b0, 2'd0, 4'h0); cycle();

    // 6. a stall on a full lane must not advance the slot
    out_ready = 4'b1101;
    drive(1'b1, 2'd1, 4'h2); cycle();
    rr_mode = 1'b1;
    drive(1'b1, 2'd0, 4'h1); cycle();
    drive(1'b1, 2'd0, 4'h3);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("stall_slot", 32'(slot), 32'h1);
    end
    out_ready = 4'b1111;
    cycle();
    check("stall_release", 32'(slot), 32'h2);
    drive(1'b0, 2'd0, 4'h0);
    repeat (3) cycle();
    check("sb_empty", 32'(sb_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_stream_demux_1_4
`default_nettype wire
